// File: rtl/rr_req_agent.sv
// rtl/rr_req_agent.sv - per-channel FIFOs feeding a round-robin arbiter and a shared 3-entry output queue
// Optional grant checker enabled by defining RR_REQ_AGENT_ERR_EN.
module rr_req_agent #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic [N-1:0]    req,
  output logic            arb_en,
  input  logic [N-1:0]    grant,
  input  logic [IW-1:0]   grant_ID,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic            err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [N][DEPTH];
  logic [PW-1:0] r_wp  [N];
  logic [PW-1:0] r_rp  [N];
  logic [CW-1:0] r_cnt [N];
  logic          r_en_q;
  logic          r_err;

  logic [W-1:0]  r_oq_data [3];
  logic [IW-1:0] r_oq_id   [3];
  logic [1:0]    r_oq_rp;
  logic [1:0]    r_oq_wp;
  logic [1:0]    r_oq_cnt;

  logic [N-1:0]  w_push;
  logic [N-1:0]  w_nonempty;
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_pop;
  logic          w_any_pop;
  logic          w_deq;
  logic          w_bad;
  logic [IW-1:0] w_pop_idx;
  logic [W-1:0]  w_pop_data;

  function automatic logic [1:0] oq_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      in_ready[i]   = (r_cnt[i] != FULL);
      w_push[i]     = in_valid[i] && in_ready[i];
    end
  end

`ifdef RR_REQ_AGENT_ERR_EN
  logic [N-1:0] w_id_hot;
  always_comb begin
    w_id_hot = N'(1) << grant_ID;
    w_bad    = r_en_q && (((grant & (grant - N'(1))) != '0) ||
                          ((grant & ~w_nonempty) != '0) ||
                          ((grant != '0) && (grant != w_id_hot)));
  end
`else
  logic w_unused_id;
  assign w_unused_id = ^grant_ID;
  assign w_bad       = 1'b0;
`endif

  // Only a grant issued on the last edge (en_q) is acted on; held grants are stale.
  assign w_cand = (r_en_q && !w_bad) ? (grant & w_nonempty) : '0;

  always_comb begin
    w_pop      = '0;
    w_pop_idx  = '0;
    w_pop_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_pop      = '0;
        w_pop[i]   = 1'b1;
        w_pop_idx  = IW'(i);
        w_pop_data = r_mem[i][r_rp[i]];
      end
    end
  end

  assign w_any_pop = |w_pop;

  always_comb begin
    for (int i = 0; i < N; i++)
      req[i] = (r_cnt[i] - {{(CW-1){1'b0}}, w_pop[i]}) != '0;
  end

  // Keeps one free slot for the grant the arbiter registers on this edge.
  assign arb_en    = ({1'b0, r_oq_cnt} + {2'b00, w_any_pop}) <= 3'd2;
  assign out_valid = (r_oq_cnt != 2'd0);
  assign out_data  = out_valid ? r_oq_data[r_oq_rp] : '0;
  assign out_id    = out_valid ? r_oq_id[r_oq_rp] : '0;
  assign w_deq     = out_valid && out_ready;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_en_q   <= 1'b0;
      r_err    <= 1'b0;
      r_oq_rp  <= 2'd0;
      r_oq_wp  <= 2'd0;
      r_oq_cnt <= 2'd0;
    end else begin
      r_en_q <= arb_en;
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wp[i]] <= in_data[i*W +: W];
          r_wp[i]           <= r_wp[i] + PW'(1);
        end
        if (w_pop[i])
          r_rp[i] <= r_rp[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      if (w_any_pop) begin
        r_oq_data[r_oq_wp] <= w_pop_data;
        r_oq_id[r_oq_wp]   <= w_pop_idx;
        r_oq_wp            <= oq_inc(r_oq_wp);
      end
      if (w_deq)
        r_oq_rp <= oq_inc(r_oq_rp);
      r_oq_cnt <= r_oq_cnt + {1'b0, w_any_pop} - {1'b0, w_deq};
      if (w_bad)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_req_agent.sv
// tb/tb_rr_req_agent.sv - randomized and directed bench with behavioural arbiter and per-channel scoreboard
module tb_rr_req_agent;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   req;
  logic           arb_en;
  logic [N-1:0]   grant;
  logic [1:0]     grant_ID;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready = 1'b1;
  logic           err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] mq [N][$];
  logic [1:0]   got_id [$];
  logic [W-1:0] got_data [$];
  int           got_cyc [$];

  logic [N-1:0] arb_grant;
  logic [1:0]   arb_id;
  int           arb_last;
  logic         force_on = 1'b0;
  logic [N-1:0] force_grant = '0;
  logic [1:0]   force_id = '0;

  always #5 clk = ~clk;

  rr_req_agent #(.N(N), .W(W), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .arb_en(arb_en), .grant(grant), .grant_ID(grant_ID),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready), .err(err)
  );

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++)
      if (r[(last + s) % N]) return (last + s) % N;
    return -1;
  endfunction

  // Round-robin arbiter: registers a new grant only on edges where en is high.
  always @(posedge clk) begin
    if (!rstn) begin
      arb_grant <= '0;
      arb_id    <= '0;
      arb_last  <= N - 1;
    end else if (arb_en) begin
      if (rr_pick(req, arb_last) < 0) begin
        arb_grant <= '0;
      end else begin
        arb_grant <= 4'b0001 << rr_pick(req, arb_last);
        arb_id    <= 2'(rr_pick(req, arb_last));
        arb_last  <= rr_pick(req, arb_last);
      end
    end
  end

  assign grant    = force_on ? force_grant : arb_grant;
  assign grant_ID = force_on ? force_id : arb_id;

  task automatic tick();
    @(negedge clk);
    if (rstn) begin
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i]) mq[i].push_back(in_data[i*W +: W]);
      if (out_valid && out_ready) begin
        got_id.push_back(out_id);
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = '0;
    force_grant = '0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) mq[i].delete();
    got_id.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL reset_req got %b want 0000", req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %h want F", in_ready); end
    checks++; if (arb_en !== 1'b1) begin errors++; $display("FAIL reset_arb_en got %b want 1", arb_en); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (out_data !== 8'h00 || out_id !== 2'd0) begin errors++; $display("FAIL reset_out_bus got %h/%0d want 00/0", out_data, out_id); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 4'b0100;
    in_data = 32'h00A5_0000;
    tick();
    in_valid = '0;
    checks++; if (req !== 4'b0100) begin errors++; $display("FAIL single_req got %b want 0100", req); end
    tick();
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL single_req_drop got %b want 0000", req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", out_data); end
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", out_id); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    logic [W-1:0] exp;
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'hF;
    in_data = $urandom();
    tick();
    in_data = $urandom();
    tick();
    in_valid = '0;
    for (int k = 0; k < 12; k++) tick();
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL fair_count got %0d want 8", got_id.size()); end
    for (int k = 0; k < got_id.size(); k++) begin
      checks++; if (got_id[k] !== 2'(k % N)) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", k, got_id[k], k % N); end
      checks++; if (got_cyc[k] != got_cyc[0] + k) begin errors++; $display("FAIL fair_rate[%0d] got cycle %0d want %0d", k, got_cyc[k], got_cyc[0] + k); end
      exp = mq[got_id[k]].size() > 0 ? mq[got_id[k]].pop_front() : 8'hxx;
      checks++; if (got_data[k] !== exp) begin errors++; $display("FAIL fair_data[%0d] got %h want %h", k, got_data[k], exp); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fair_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom();
      tick();
    end
    in_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (arb_en !== 1'b0) begin errors++; $display("FAIL bp_arb_en got %b want 0", arb_en); end
    checks++; if (req !== 4'b0001) begin errors++; $display("FAIL bp_req got %b want 0001 (one left in ch0)", req); end
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL bp_in_ready got %h want F", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== mq[0][0]) begin errors++; $display("FAIL bp_head got %b/%h want 1/%h", out_valid, out_data, mq[0][0]); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (got_id.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got_id.size()); end
    for (int k = 0; k < got_id.size(); k++) begin
      exp = mq[0].size() > 0 ? mq[0].pop_front() : 8'hxx;
      checks++; if (got_id[k] !== 2'd0 || got_data[k] !== exp) begin errors++; $display("FAIL bp_data[%0d] got %0d/%h want 0/%h", k, got_id[k], got_data[k], exp); end
    end
  endtask

  task automatic test_full_fifo();
    logic [W-1:0] exp;
    int total;
    do_reset();
    out_ready = 1'b1;
    force_on = 1'b1;
    force_grant = '0;
    in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      checks++; if (in_ready[1] !== (k < 4)) begin errors++; $display("FAIL full_ready[%0d] got %b want %b", k, in_ready[1], k < 4); end
      in_data = $urandom();
      tick();
    end
    checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", in_ready[1]); end
    force_grant = 4'b0010;
    force_id = 2'd1;
    tick();
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL full_after_pop got %b want 1", in_ready[1]); end
    in_data = $urandom();
    tick();
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL full_push_pop got %b want 1", in_ready[1]); end
    force_grant = '0;
    in_data = $urandom();
    tick();
    checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL full_refill got %b want 0", in_ready[1]); end
    in_valid = '0;
    force_on = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    checks++; if (got_id.size() != 6) begin errors++; $display("FAIL full_count got %0d want 6", got_id.size()); end
    total = got_id.size();
    for (int k = 0; k < total; k++) begin
      exp = mq[1].size() > 0 ? mq[1].pop_front() : 8'hxx;
      checks++; if (got_id[k] !== 2'd1 || got_data[k] !== exp) begin errors++; $display("FAIL full_data[%0d] got %0d/%h want 1/%h", k, got_id[k], got_data[k], exp); end
    end
  endtask

  task automatic test_reset_midop();
    force_on = 1'b1;
    force_grant = '0;
    in_valid = 4'hF;
    in_data = $urandom();
    tick();
    tick();
    in_valid = '0;
    do_reset();
    force_on = 1'b0;
    checks++; if (req !== 4'b0000 || in_ready !== 4'hF) begin errors++; $display("FAIL midrst_state got req %b rdy %h want 0000 F", req, in_ready); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (got_id.size() != 0) begin errors++; $display("FAIL midrst_leak got %0d outputs want 0", got_id.size()); end
  endtask

  task automatic test_errors();
`ifdef RR_REQ_AGENT_ERR_EN
    force_on = 1'b1;
    do_reset();
    in_valid = 4'b0111;
    in_data = $urandom();
    tick();
    in_valid = '0;
    force_grant = 4'b0011;
    force_id = 2'd0;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_multihot got %b want 1", err); end
    checks++; if (req !== 4'b0111 || out_valid !== 1'b0) begin errors++; $display("FAIL err_multihot_pop got req %b ov %b want 0111 0", req, out_valid); end
    do_reset();
    tick();
    force_grant = 4'b1000;
    force_id = 2'd3;
    tick();
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL err_empty got %b/%b want 1/0", err, out_valid); end
    do_reset();
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    force_grant = 4'b0100;
    force_id = 2'd1;
    tick();
    checks++; if (err !== 1'b1 || req !== 4'b0100) begin errors++; $display("FAIL err_id got err %b req %b want 1 0100", err, req); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
`else
    force_on = 1'b1;
    do_reset();
    tick();
    force_grant = 4'b1000;
    force_id = 2'd3;
    tick();
    tick();
    checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL noerr_empty got %b/%b want 0/0", err, out_valid); end
`endif
    force_on = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    int left;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid = 4'($urandom());
      in_data = $urandom();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    for (int k = 0; k < got_id.size(); k++) begin
      exp = mq[got_id[k]].size() > 0 ? mq[got_id[k]].pop_front() : 8'hxx;
      checks++; if (got_data[k] !== exp) begin errors++; $display("FAIL rand_data[%0d] ch%0d got %h want %h", k, got_id[k], got_data[k], exp); end
    end
    left = 0;
    for (int i = 0; i < N; i++) left += mq[i].size();
    checks++; if (left != 0) begin errors++; $display("FAIL rand_lost got %0d undelivered want 0", left); end
    checks++; if (out_valid !== 1'b0 || req !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL rand_idle got ov %b req %b err %b want 0 0000 0", out_valid, req, err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_full_fifo();
    test_reset_midop();
    test_errors();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
